// File: rtl/sram_arbiter.sv
// sram_arbiter
//
// Owns the board SRAM pins and shares the single 16-bit frame buffer
// between the display scan-out reader and two pixel writers. A display
// read always wins arbitration. The two writers alternate through a
// round-robin pointer. Every SRAM-side output comes straight from a
// flop. The data bus is driven only while the write strobe is low.
//
// Parameters
//   DATA_W        SRAM data width (16 on this board)
//   WR_CYCLES     cycles o_sram_we_n is held low per write, 1..7
//   STARVE_LIMIT  consecutive display grants tolerated while a writer waits
//
// Build option
//   SRAM_ARB_STARVE_GUARD_EN  when defined, a writer is forced through
//                             after STARVE_LIMIT back-to-back display grants.
//                             When undefined, the display has strict priority.
//
// Ports
//   clk, rst               clock; asynchronous active-low reset
//   i_disp_req/addr        display read request, held until o_disp_rvalid
//   o_disp_rdata/rvalid    read data with one-cycle valid pulse
//   i_wN_req/addr/data     writer N request, held until o_wN_gnt
//   o_wN_gnt               one-cycle pulse: writer N address/data taken
//   o_sram_addr            SRAM word address
//   io_sram_data           SRAM data bus (high-Z unless writing)
//   o_sram_we_n/oe_n       SRAM strobes, active low, never low together
//   o_busy                 arbiter is not idle
module sram_arbiter #(
  parameter int DATA_W       = 16,
  parameter int WR_CYCLES    = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_disp_req,
  input  logic [20:1]       i_disp_addr,
  output logic [DATA_W-1:0] o_disp_rdata,
  output logic              o_disp_rvalid,
  input  logic              i_w0_req,
  input  logic [20:1]       i_w0_addr,
  input  logic [DATA_W-1:0] i_w0_data,
  input  logic              i_w1_req,
  input  logic [20:1]       i_w1_addr,
  input  logic [DATA_W-1:0] i_w1_data,
  output logic              o_w0_gnt,
  output logic              o_w1_gnt,
  output logic [20:1]       o_sram_addr,
  inout  wire  [DATA_W-1:0] io_sram_data,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic              o_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_TURN  = 2'd3;

  // The write counter counts down to zero, so it is loaded with one less
  // than the number of strobe-low cycles.
  localparam logic [2:0] WR_LOAD = 3'(WR_CYCLES - 1);

  if (WR_CYCLES < 1 || WR_CYCLES > 7) begin : g_bad_wr_cycles
    $error("sram_arbiter: WR_CYCLES must be in 1..7");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("sram_arbiter: STARVE_LIMIT must be at least 1");
  end

  logic [1:0]        state;
  logic [2:0]        wr_cnt;
  logic              rr_ptr;      // 0: w0 has first claim, 1: w1 has first claim
  logic [DATA_W-1:0] wr_data;
  logic              starve_hit;

  logic any_w;
  logic pick_w1;
  logic grant_rd;
  logic grant_wr;

  // Arbitration for the IDLE cycle. When the pointer favours a writer that is
  // not requesting, the other writer is picked. The result is only
  // meaningful when at least one writer is requesting.
  always_comb begin
    any_w    = i_w0_req | i_w1_req;
    pick_w1  = rr_ptr ? i_w1_req : ~i_w0_req;
    grant_rd = i_disp_req & ~(starve_hit & any_w);
    grant_wr = ~grant_rd & any_w;
  end

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [STV_W-1:0] starve_cnt;

  assign starve_hit = (starve_cnt >= STV_W'(STARVE_LIMIT));

  // The counter runs only while a writer is kept waiting. A display grant
  // with no writer pending breaks the run. The forced writer grant at the
  // limit clears the counter, so it never passes STARVE_LIMIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (grant_wr) begin
        starve_cnt <= '0;
      end else if (grant_rd) begin
        starve_cnt <= any_w ? starve_cnt + 1'b1 : '0;
      end
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  // Control state and all SRAM/handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      wr_cnt        <= '0;
      rr_ptr        <= 1'b0;
      o_sram_addr   <= '0;
      o_sram_we_n   <= 1'b1;
      o_sram_oe_n   <= 1'b1;
      o_w0_gnt      <= 1'b0;
      o_w1_gnt      <= 1'b0;
      o_disp_rvalid <= 1'b0;
      o_disp_rdata  <= '0;
    end else begin
      o_w0_gnt      <= 1'b0;
      o_w1_gnt      <= 1'b0;
      o_disp_rvalid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_rd) begin
            state       <= S_READ;
            o_sram_addr <= i_disp_addr;
            o_sram_oe_n <= 1'b0;
          end else if (grant_wr) begin
            state       <= S_WRITE;
            o_sram_addr <= pick_w1 ? i_w1_addr : i_w0_addr;
            o_sram_we_n <= 1'b0;
            wr_cnt      <= WR_LOAD;
            o_w0_gnt    <= ~pick_w1;
            o_w1_gnt    <= pick_w1;
            rr_ptr      <= ~pick_w1;
          end
        end
        S_READ: begin
          // The SRAM has had the whole cycle with OE low, so the bus is
          // stable at this edge.
          o_disp_rdata  <= io_sram_data;
          o_disp_rvalid <= 1'b1;
          o_sram_oe_n   <= 1'b1;
          state         <= S_IDLE;
        end
        S_WRITE: begin
          if (wr_cnt == 3'd0) begin
            o_sram_we_n <= 1'b1;
            state       <= S_TURN;
          end else begin
            wr_cnt <= wr_cnt - 3'd1;
          end
        end
        S_TURN: begin
          // One dead cycle so that the SRAM output driver and ours never
          // overlap when a read follows a write.
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Write data holding register. It is only meaningful while the write
  // strobe is low, so it has no reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && grant_wr) begin
      wr_data <= pick_w1 ? i_w1_data : i_w0_data;
    end
  end

  assign io_sram_data = o_sram_we_n ? {DATA_W{1'bz}} : wr_data;
  assign o_busy       = (state != S_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  localparam int WR_CYCLES    = 2;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_disp_req;
  logic [20:1] i_disp_addr;
  logic [15:0] o_disp_rdata;
  logic        o_disp_rvalid;
  logic        i_w0_req;
  logic [20:1] i_w0_addr;
  logic [15:0] i_w0_data;
  logic        i_w1_req;
  logic [20:1] i_w1_addr;
  logic [15:0] i_w1_data;
  logic        o_w0_gnt;
  logic        o_w1_gnt;
  logic [20:1] o_sram_addr;
  wire  [15:0] sram_bus;
  logic        o_sram_we_n;
  logic        o_sram_oe_n;
  logic        o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Contents of the SRAM model: a fixed function of the address, with the
  // one word the read test looks for.
  function automatic logic [15:0] sram_word(input logic [20:1] a);
    if (a == 20'h00123) return 16'hBEEF;
    return a[16:1] ^ {a[20:17], 12'h3C5};
  endfunction

  assign sram_bus = (!o_sram_oe_n) ? sram_word(o_sram_addr) : 16'bz;

  always #5 clk = ~clk;

  sram_arbiter #(
    .DATA_W(16),
    .WR_CYCLES(WR_CYCLES),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_disp_req(i_disp_req),
    .i_disp_addr(i_disp_addr),
    .o_disp_rdata(o_disp_rdata),
    .o_disp_rvalid(o_disp_rvalid),
    .i_w0_req(i_w0_req),
    .i_w0_addr(i_w0_addr),
    .i_w0_data(i_w0_data),
    .i_w1_req(i_w1_req),
    .i_w1_addr(i_w1_addr),
    .i_w1_data(i_w1_data),
    .o_w0_gnt(o_w0_gnt),
    .o_w1_gnt(o_w1_gnt),
    .o_sram_addr(o_sram_addr),
    .io_sram_data(sram_bus),
    .o_sram_we_n(o_sram_we_n),
    .o_sram_oe_n(o_sram_oe_n),
    .o_busy(o_busy)
  );

  typedef struct {
    logic        oe_n;
    logic        we_n;
    logic        busy;
    logic        g0;
    logic        g1;
    logic        rv;
    logic        chk_addr;
    logic [20:1] addr;
    logic [15:0] data;
  } exp_t;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_disp_req  = 1'b0;
    i_disp_addr = '0;
    i_w0_req    = 1'b0;
    i_w0_addr   = '0;
    i_w0_data   = '0;
    i_w1_req    = 1'b0;
    i_w1_addr   = '0;
    i_w1_data   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    cyc();
    cyc();
    n_tests++; if (o_sram_oe_n !== 1'b1) begin n_fail++; $display("FAIL reset_oe_n got %b want 1", o_sram_oe_n); end
    n_tests++; if (o_sram_we_n !== 1'b1) begin n_fail++; $display("FAIL reset_we_n got %b want 1", o_sram_we_n); end
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", o_busy); end
    n_tests++; if ({o_w0_gnt, o_w1_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got %b want 00", {o_w0_gnt, o_w1_gnt}); end
    n_tests++; if (o_disp_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b want 0", o_disp_rvalid); end
    n_tests++; if (o_disp_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata got %h want 0000", o_disp_rdata); end
    n_tests++; if (o_sram_addr !== 20'h00000) begin n_fail++; $display("FAIL reset_addr got %h want 00000", o_sram_addr); end
    rst = 1'b1;
    cyc();
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_after got busy %b want 0", o_busy); end
  endtask

  task automatic test_single_read();
    do_reset();
    i_disp_req  = 1'b1;
    i_disp_addr = 20'h00123;
    cyc();
    n_tests++; if (o_sram_oe_n !== 1'b0) begin n_fail++; $display("FAIL read_oe_low got %b want 0", o_sram_oe_n); end
    n_tests++; if (o_sram_addr !== 20'h00123) begin n_fail++; $display("FAIL read_addr got %h want 00123", o_sram_addr); end
    n_tests++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL read_busy got %b want 1", o_busy); end
    n_tests++; if (o_disp_rvalid !== 1'b0) begin n_fail++; $display("FAIL read_early_rvalid got %b want 0", o_disp_rvalid); end
    cyc();
    i_disp_req = 1'b0;
    n_tests++; if (o_disp_rvalid !== 1'b1) begin n_fail++; $display("FAIL read_rvalid got %b want 1", o_disp_rvalid); end
    n_tests++; if (o_disp_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL read_rdata got %h want BEEF", o_disp_rdata); end
    n_tests++; if (o_sram_oe_n !== 1'b1) begin n_fail++; $display("FAIL read_oe_one_cycle got %b want 1", o_sram_oe_n); end
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL read_back_idle got busy %b want 0", o_busy); end
    cyc();
    n_tests++; if (o_disp_rvalid !== 1'b0) begin n_fail++; $display("FAIL read_rvalid_pulse got %b want 0", o_disp_rvalid); end
    n_tests++; if (o_disp_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL read_rdata_hold got %h want BEEF", o_disp_rdata); end
  endtask

  task automatic test_single_write();
    do_reset();
    i_w0_req  = 1'b1;
    i_w0_addr = 20'h00010;
    i_w0_data = 16'h1234;
    cyc();
    i_w0_req = 1'b0;
    n_tests++; if (o_w0_gnt !== 1'b1) begin n_fail++; $display("FAIL write_gnt got %b want 1", o_w0_gnt); end
    n_tests++; if (o_sram_we_n !== 1'b0) begin n_fail++; $display("FAIL write_we_first got %b want 0", o_sram_we_n); end
    n_tests++; if (sram_bus !== 16'h1234) begin n_fail++; $display("FAIL write_bus got %h want 1234", sram_bus); end
    n_tests++; if (o_sram_addr !== 20'h00010) begin n_fail++; $display("FAIL write_addr got %h want 00010", o_sram_addr); end
    for (int i = 1; i < WR_CYCLES; i++) begin
      cyc();
      n_tests++; if (o_w0_gnt !== 1'b0) begin n_fail++; $display("FAIL write_gnt_pulse cyc %0d got %b want 0", i, o_w0_gnt); end
      n_tests++; if (o_sram_we_n !== 1'b0) begin n_fail++; $display("FAIL write_we_hold cyc %0d got %b want 0", i, o_sram_we_n); end
      n_tests++; if (sram_bus !== 16'h1234) begin n_fail++; $display("FAIL write_bus_hold cyc %0d got %h want 1234", i, sram_bus); end
    end
    cyc();
    n_tests++; if ({o_sram_we_n, o_sram_oe_n, o_busy} !== 3'b111) begin n_fail++; $display("FAIL write_turn we/oe/busy got %b want 111", {o_sram_we_n, o_sram_oe_n, o_busy}); end
    cyc();
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL write_back_idle got busy %b want 0", o_busy); end
  endtask

  task automatic test_alternate();
    int seq[$];
    int overlap;
    overlap = 0;
    do_reset();
    i_w0_req = 1'b1; i_w0_addr = 20'h00200; i_w0_data = 16'h0A0A;
    i_w1_req = 1'b1; i_w1_addr = 20'h00300; i_w1_data = 16'h0B0B;
    for (int c = 0; c < 4 * (WR_CYCLES + 2); c++) begin
      cyc();
      if (!o_sram_oe_n && !o_sram_we_n) overlap++;
      if (o_w0_gnt) seq.push_back(0);
      if (o_w1_gnt) seq.push_back(1);
    end
    idle_inputs();
    n_tests++; if (seq.size() != 4) begin n_fail++; $display("FAIL alt_count got %0d grants want 4", seq.size()); end
    for (int i = 0; i < 4 && i < seq.size(); i++) begin
      n_tests++; if (seq[i] != (i % 2)) begin n_fail++; $display("FAIL alt_order slot %0d got w%0d want w%0d", i, seq[i], i % 2); end
    end
    n_tests++; if (overlap != 0) begin n_fail++; $display("FAIL alt_strobe_overlap got %0d cycles want 0", overlap); end
  endtask

  task automatic test_priority_all();
    int t_oe, t_rv, t_g0, t_g1;
    logic [15:0] rd;
    t_oe = -1; t_rv = -1; t_g0 = -1; t_g1 = -1; rd = '0;
    do_reset();
    i_disp_req = 1'b1; i_disp_addr = 20'h0ABCD;
    i_w0_req = 1'b1; i_w0_addr = 20'h00400; i_w0_data = 16'h4444;
    i_w1_req = 1'b1; i_w1_addr = 20'h00500; i_w1_data = 16'h5555;
    for (int c = 1; c <= 14; c++) begin
      cyc();
      if (!o_sram_oe_n && t_oe < 0) t_oe = c;
      if (o_disp_rvalid) begin t_rv = c; rd = o_disp_rdata; i_disp_req = 1'b0; end
      if (o_w0_gnt) begin t_g0 = c; i_w0_req = 1'b0; end
      if (o_w1_gnt) begin t_g1 = c; i_w1_req = 1'b0; end
    end
    n_tests++; if (t_oe != 1) begin n_fail++; $display("FAIL prio_read_first got oe at %0d want 1", t_oe); end
    n_tests++; if (t_rv != 2) begin n_fail++; $display("FAIL prio_rvalid got %0d want 2", t_rv); end
    n_tests++; if (rd !== sram_word(20'h0ABCD)) begin n_fail++; $display("FAIL prio_rdata got %h want %h", rd, sram_word(20'h0ABCD)); end
    n_tests++; if (t_g0 != 3) begin n_fail++; $display("FAIL prio_w0 got %0d want 3", t_g0); end
    n_tests++; if (t_g1 != 3 + WR_CYCLES + 2) begin n_fail++; $display("FAIL prio_w1 got %0d want %0d", t_g1, 3 + WR_CYCLES + 2); end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    i_w1_req = 1'b1; i_w1_addr = 20'h00777; i_w1_data = 16'hC3C3;
    cyc();
    i_w1_req = 1'b0;
    n_tests++; if (o_sram_we_n !== 1'b0) begin n_fail++; $display("FAIL midrst_pre_we got %b want 0", o_sram_we_n); end
    n_tests++; if (sram_bus !== 16'hC3C3) begin n_fail++; $display("FAIL midrst_pre_bus got %h want C3C3", sram_bus); end
    #2;
    rst = 1'b0;
    #1;
    n_tests++; if (o_sram_we_n !== 1'b1) begin n_fail++; $display("FAIL midrst_we got %b want 1", o_sram_we_n); end
    n_tests++; if (o_sram_oe_n !== 1'b1) begin n_fail++; $display("FAIL midrst_oe got %b want 1", o_sram_oe_n); end
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", o_busy); end
    n_tests++; if (o_w1_gnt !== 1'b0) begin n_fail++; $display("FAIL midrst_gnt got %b want 0", o_w1_gnt); end
    n_tests++; if (o_sram_addr !== 20'h00000) begin n_fail++; $display("FAIL midrst_addr got %h want 00000", o_sram_addr); end
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_starvation();
    int rv_before, rv_after, g1;
    rv_before = 0; rv_after = 0; g1 = 0;
    do_reset();
    i_disp_req = 1'b1; i_disp_addr = 20'($urandom);
    i_w1_req = 1'b1; i_w1_addr = 20'h01000; i_w1_data = 16'h7E7E;
    for (int c = 0; c < 40; c++) begin
      cyc();
      if (o_disp_rvalid) begin
        if (g1 == 0) rv_before++; else rv_after++;
        i_disp_addr = 20'($urandom);
      end
      if (o_w1_gnt) begin g1++; i_w1_req = 1'b0; end
    end
    idle_inputs();
`ifdef SRAM_ARB_STARVE_GUARD_EN
    n_tests++; if (g1 != 1) begin n_fail++; $display("FAIL starve_w1_gnt got %0d want 1", g1); end
    n_tests++; if (rv_before != STARVE_LIMIT) begin n_fail++; $display("FAIL starve_reads_before got %0d want %0d", rv_before, STARVE_LIMIT); end
    n_tests++; if (rv_after != (39 - (2 * STARVE_LIMIT + WR_CYCLES + 3)) / 2 + 1) begin
      n_fail++; $display("FAIL starve_reads_after got %0d want %0d", rv_after, (39 - (2 * STARVE_LIMIT + WR_CYCLES + 3)) / 2 + 1);
    end
`else
    n_tests++; if (g1 != 0) begin n_fail++; $display("FAIL starve_w1_gnt got %0d want 0", g1); end
    n_tests++; if (rv_before != 20) begin n_fail++; $display("FAIL starve_reads got %0d want 20", rv_before); end
`endif
    cyc();
    cyc();
  endtask

  task automatic test_random();
    exp_t        q[$];
    exp_t        e;
    exp_t        idle_e;
    logic        d_req;
    logic [20:1] d_addr;
    logic        wr[2];
    logic [20:1] wa[2];
    logic [15:0] wd[2];
    logic        s_d;
    logic [20:1] s_da;
    logic        s_w[2];
    logic [20:1] s_wa[2];
    logic [15:0] s_wd[2];
    logic [15:0] exp_rdata;
    logic        any_w;
    logic        starve_hit;
    logic        was_req;
    int          ptr;
    int          starve;
    int          pick;

    idle_e.oe_n = 1'b1; idle_e.we_n = 1'b1; idle_e.busy = 1'b0;
    idle_e.g0 = 1'b0; idle_e.g1 = 1'b0; idle_e.rv = 1'b0; idle_e.chk_addr = 1'b0;
    idle_e.addr = '0; idle_e.data = '0;
    d_req = 1'b0; d_addr = '0;
    for (int k = 0; k < 2; k++) begin wr[k] = 1'b0; wa[k] = '0; wd[k] = '0; end
    exp_rdata = '0; ptr = 0; starve = 0;
    do_reset();

    for (int c = 0; c < 3000; c++) begin
      i_disp_req = d_req; i_disp_addr = d_addr;
      i_w0_req = wr[0]; i_w0_addr = wa[0]; i_w0_data = wd[0];
      i_w1_req = wr[1]; i_w1_addr = wa[1]; i_w1_data = wd[1];
      s_d = d_req; s_da = d_addr;
      for (int k = 0; k < 2; k++) begin s_w[k] = wr[k]; s_wa[k] = wa[k]; s_wd[k] = wd[k]; end
      cyc();

      // Reference: an idle arbiter decides on the requests present at this
      // edge and the resulting access is laid out as a per-cycle schedule.
      if (q.size() == 0) begin
        any_w = s_w[0] | s_w[1];
        starve_hit = 1'b0;
`ifdef SRAM_ARB_STARVE_GUARD_EN
        starve_hit = (starve >= STARVE_LIMIT);
`endif
        if (s_d && !(starve_hit && any_w)) begin
          if (any_w) starve++; else starve = 0;
          e = idle_e; e.oe_n = 1'b0; e.busy = 1'b1; e.chk_addr = 1'b1; e.addr = s_da;
          q.push_back(e);
          e = idle_e; e.rv = 1'b1; e.data = sram_word(s_da);
          q.push_back(e);
        end else if (any_w) begin
          pick = s_w[ptr] ? ptr : 1 - ptr;
          ptr = 1 - pick;
          starve = 0;
          for (int k = 0; k < WR_CYCLES; k++) begin
            e = idle_e; e.we_n = 1'b0; e.busy = 1'b1; e.chk_addr = 1'b1;
            e.addr = s_wa[pick]; e.data = s_wd[pick];
            e.g0 = (k == 0 && pick == 0); e.g1 = (k == 0 && pick == 1);
            q.push_back(e);
          end
          e = idle_e; e.busy = 1'b1;
          q.push_back(e);
          q.push_back(idle_e);
        end
      end
      if (q.size() != 0) e = q.pop_front(); else e = idle_e;
      if (e.rv) exp_rdata = e.data;

      n_tests++;
      if ({o_sram_oe_n, o_sram_we_n, o_busy, o_w0_gnt, o_w1_gnt, o_disp_rvalid} !==
          {e.oe_n, e.we_n, e.busy, e.g0, e.g1, e.rv}) begin
        n_fail++;
        $display("FAIL rand_ctrl cycle %0d oe/we/busy/g0/g1/rv got %b want %b", c,
                 {o_sram_oe_n, o_sram_we_n, o_busy, o_w0_gnt, o_w1_gnt, o_disp_rvalid},
                 {e.oe_n, e.we_n, e.busy, e.g0, e.g1, e.rv});
      end
      n_tests++;
      if (o_disp_rdata !== exp_rdata) begin
        n_fail++; $display("FAIL rand_rdata cycle %0d got %h want %h", c, o_disp_rdata, exp_rdata);
      end
      if (e.chk_addr) begin
        n_tests++;
        if (o_sram_addr !== e.addr) begin
          n_fail++; $display("FAIL rand_addr cycle %0d got %h want %h", c, o_sram_addr, e.addr);
        end
      end
      if (!e.we_n) begin
        n_tests++;
        if (sram_bus !== e.data) begin
          n_fail++; $display("FAIL rand_bus cycle %0d got %h want %h", c, sram_bus, e.data);
        end
      end

      // Requesters: the display holds until its data returns; writers hold
      // until granted but occasionally give up.
      if (e.rv) d_req = 1'b0;
      if (!d_req && $urandom_range(3) == 0) begin
        d_req = 1'b1; d_addr = 20'($urandom);
      end
      for (int k = 0; k < 2; k++) begin
        was_req = wr[k];
        if ((k == 0 && e.g0) || (k == 1 && e.g1)) begin
          wr[k] = 1'b0;
          was_req = 1'b0;
        end else if (wr[k] && $urandom_range(15) == 0) begin
          wr[k] = 1'b0;
        end
        if (!was_req && !wr[k] && $urandom_range(2) == 0) begin
          wr[k] = 1'b1; wa[k] = 20'($urandom); wd[k] = 16'($urandom);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_single_write();
    test_alternate();
    test_priority_all();
    test_reset_mid_write();
    test_starvation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
